// File: rtl/imem_loader.sv
// Writable 32 x 13-bit instruction store for the processor, filled at run time
// from a valid/ready word stream; fetch reads combinationally and sees NOP while loading.
module imem_loader #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded_len
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LAST_CLR_L = LEN_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [LEN_W-1:0]  wr_ptr_r, wr_ptr_s;
    logic [LEN_W-1:0]  clr_ptr_r, clr_ptr_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [LEN_W-1:0]  loaded_len_r, loaded_len_s;
    logic [LEN_W-1:0]  wr_ptr_nx_s;
    logic              len_ok_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    assign len_ok_s    = (load_len != LEN_W'(0)) && (load_len <= DEPTH_L);
    assign wr_ptr_nx_s = wr_ptr_r + LEN_W'(1);

    // Next-state, counter and write-port decode
    always_comb begin
        state_s      = state_r;
        len_s        = len_r;
        wr_ptr_s     = wr_ptr_r;
        clr_ptr_s    = clr_ptr_r;
        loaded_len_s = loaded_len_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        we_s         = 1'b0;
        waddr_s      = '0;
        wdata_s      = '0;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    if (len_ok_s) begin
                        len_s     = load_len;
                        wr_ptr_s  = '0;
                        clr_ptr_s = '0;
                        state_s   = CLEAR;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                // Wipe the whole store so entries beyond the new program read as NOP
                we_s    = 1'b1;
                waddr_s = clr_ptr_r[ADDR_W-1:0];
                wdata_s = '0;
                if (clr_ptr_r == LAST_CLR_L) begin
                    clr_ptr_s = '0;
                    state_s   = LOAD;
                end else begin
                    clr_ptr_s = clr_ptr_r + LEN_W'(1);
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_s     = 1'b1;
                    waddr_s  = wr_ptr_r[ADDR_W-1:0];
                    wdata_s  = in_data;
                    wr_ptr_s = wr_ptr_nx_s;
                    if (wr_ptr_nx_s == len_r) begin
                        done_s       = 1'b1;
                        loaded_len_s = len_r;
                        state_s      = DONE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            len_r        <= '0;
            wr_ptr_r     <= '0;
            clr_ptr_r    <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            loaded_len_r <= '0;
        end else begin
            state_r      <= state_s;
            len_r        <= len_s;
            wr_ptr_r     <= wr_ptr_s;
            clr_ptr_r    <= clr_ptr_s;
            done_r       <= done_s;
            err_r        <= err_s;
            loaded_len_r <= loaded_len_s;
        end
    end

    // Instruction store; deliberately not reset so a reset keeps existing contents
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    assign in_ready    = (state_r == LOAD);
    assign cpu_hold    = (state_r != IDLE);
    assign done        = done_r;
    assign err         = err_r;
    assign loaded_len  = loaded_len_r;
    assign fetch_instr = cpu_hold ? '0 : mem_r[fetch_addr];

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads,
// checked every cycle against a transaction-level model of the instruction store.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start = 1'b0;
    logic [5:0]  load_len = 6'd0;
    logic        in_valid = 1'b0;
    logic [12:0] in_data = 13'd0;
    logic        in_ready;
    logic [4:0]  fetch_addr = 5'd0;
    logic [12:0] fetch_instr;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [5:0]  loaded_len;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    bit started = 1'b0;

    logic [12:0] words [32];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .loaded_len (loaded_len)
    );

    // Behavioural model: clearing cycles left, words left, one-cycle pulses
    logic [12:0] m_mem [32];
    bit          m_known [32];
    int          m_clear_left = 0;
    int          m_wptr = 0;
    int          m_len = 0;
    int          m_loaded = 0;
    bit          m_in_load = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    bit          m_was_idle;
    bit          m_nd;
    bit          m_ne;

    function automatic bit m_hold();
        return (m_clear_left > 0) || m_in_load || m_done;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_left = 0;
            m_in_load    = 1'b0;
            m_done       = 1'b0;
            m_err        = 1'b0;
            m_loaded     = 0;
            m_wptr       = 0;
            m_len        = 0;
        end else begin
            m_was_idle = !m_hold();
            m_nd = 1'b0;
            m_ne = 1'b0;
            if (m_was_idle) begin
                if (load_start) begin
                    if (load_len >= 6'd1 && load_len <= 6'd32) begin
                        m_len        = int'(load_len);
                        m_wptr       = 0;
                        m_clear_left = 32;
                    end else begin
                        m_ne = 1'b1;
                    end
                end
            end else if (m_clear_left > 0) begin
                m_mem[32 - m_clear_left]   = 13'h0000;
                m_known[32 - m_clear_left] = 1'b1;
                m_clear_left = m_clear_left - 1;
                if (m_clear_left == 0) m_in_load = 1'b1;
            end else if (m_in_load) begin
                if (in_valid) begin
                    m_mem[m_wptr]   = in_data;
                    m_known[m_wptr] = 1'b1;
                    m_wptr = m_wptr + 1;
                    if (m_wptr == m_len) begin
                        m_in_load = 1'b0;
                        m_nd      = 1'b1;
                        m_loaded  = m_len;
                    end
                end
            end
            m_done = m_nd;
            m_err  = m_ne;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (started) begin
            chk("cpu_hold", 32'(cpu_hold), 32'(m_hold()));
            chk("in_ready", 32'(in_ready), 32'(m_in_load));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("loaded_len", 32'(loaded_len), 32'(m_loaded));
            if (m_hold()) chk("fetch_hold", 32'(fetch_instr), 32'h0);
            else if (m_known[fetch_addr]) chk("fetch", 32'(fetch_instr), 32'(m_mem[fetch_addr]));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int len, output int lat);
        fetch_addr = 5'd0;
        load_start = 1'b1;
        load_len   = 6'(len);
        step();
        load_start = 1'b0;
        lat = 1;
        while (in_ready !== 1'b1 && lat < 60) begin
            chk("clear_hold", 32'(cpu_hold), 32'h1);
            chk("clear_fetch0", 32'(fetch_instr), 32'h0);
            step();
            lat++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", 32'(in_ready), 32'h1);
    endtask

    // gap: 0 back-to-back, 1 valid every other cycle, 2 random with fetch/start noise
    task automatic stream(input int n, input int gap);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 400) begin
            case (gap)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = words[i];
            if (gap == 2) begin
                fetch_addr = 5'($urandom_range(0, 31));
                load_start = ($urandom_range(0, 3) == 0);
                load_len   = 6'($urandom_range(0, 63));
            end
            if (in_valid && in_ready === 1'b1) i++;
            step();
            cyc++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        if (i < n) chk("stream_timeout", 32'(i), 32'(n));
    endtask

    task automatic rd(input logic [4:0] a, input logic [12:0] e, input string nm);
        step();
        fetch_addr = a;
        #1;
        chk(nm, 32'(fetch_instr), 32'(e));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_len", 32'(loaded_len), 32'h0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int lat;
        int d0;
        int len;
        int r;
        #1 rst_n = 1'b0;
        #1 started = 1'b1;
        step();
        step();
        chk("reset_hold", 32'(cpu_hold), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_len", 32'(loaded_len), 32'h0);
        rst_n = 1'b1;
        step();

        // Three words back to back
        words[0] = 13'h1c00; words[1] = 13'h1c11; words[2] = 13'h0208;
        d0 = n_done;
        start_load(3, lat);
        chk("t1_ready_latency", 32'(lat), 32'd33);
        stream(3, 0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_loaded_len", 32'(loaded_len), 32'd3);
        step();
        chk("t1_done_low", 32'(done), 32'h0);
        chk("t1_hold_low", 32'(cpu_hold), 32'h0);
        rd(5'd0, 13'h1c00, "t1_e0");
        rd(5'd1, 13'h1c11, "t1_e1");
        rd(5'd2, 13'h0208, "t1_e2");
        rd(5'd5, 13'h0000, "t1_e5");
        chk("t1_done_once", 32'(n_done - d0), 32'd1);

        // Full load with gaps
        for (int i = 0; i < 32; i++) words[i] = 13'h1000 + 13'(i);
        start_load(32, lat);
        stream(32, 1);
        chk("t2_loaded_len", 32'(loaded_len), 32'd32);
        step();
        rd(5'd31, 13'h101f, "t2_e31");
        rd(5'd0, 13'h1000, "t2_e0");

        // Illegal lengths
        load_start = 1'b1; load_len = 6'd0;
        step();
        load_start = 1'b0;
        chk("t3_err0", 32'(err), 32'h1);
        chk("t3_hold0", 32'(cpu_hold), 32'h0);
        step();
        chk("t3_err0_low", 32'(err), 32'h0);
        load_start = 1'b1; load_len = 6'd33;
        step();
        load_start = 1'b0;
        chk("t3_err33", 32'(err), 32'h1);
        step();
        chk("t3_err33_low", 32'(err), 32'h0);
        chk("t3_hold33", 32'(cpu_hold), 32'h0);
        chk("t3_len_kept", 32'(loaded_len), 32'd32);
        rd(5'd7, 13'h1007, "t3_e7");

        // Two-word load with an ignored restart, then a one-word reload
        words[0] = 13'h0aaa; words[1] = 13'h0555;
        start_load(2, lat);
        load_start = 1'b1; load_len = 6'd7;
        step();
        load_start = 1'b0;
        stream(2, 0);
        chk("t4_len2", 32'(loaded_len), 32'd2);
        step();
        words[0] = 13'h1e08;
        start_load(1, lat);
        stream(1, 0);
        step();
        rd(5'd0, 13'h1e08, "t4_e0");
        rd(5'd1, 13'h0000, "t4_e1");
        chk("t4_len1", 32'(loaded_len), 32'd1);

        // Reset after two of four words
        words[0] = 13'h0111; words[1] = 13'h0222; words[2] = 13'h0333; words[3] = 13'h0444;
        d0 = n_done;
        start_load(4, lat);
        stream(2, 0);
        pulse_reset();
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        rd(5'd0, 13'h0111, "t6_e0");
        rd(5'd1, 13'h0222, "t6_e1");
        rd(5'd2, 13'h0000, "t6_e2");
        rd(5'd3, 13'h0000, "t6_e3");

        // Randomized loads
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                load_start = 1'b1;
                load_len = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(33, 63));
                step();
                load_start = 1'b0;
                step();
            end else begin
                len = int'($urandom_range(1, 32));
                for (int i = 0; i < 32; i++) words[i] = 13'($urandom);
                start_load(len, lat);
                chk("rand_ready_latency", 32'(lat), 32'd33);
                if (r == 1) begin
                    stream(len / 2, 2);
                    pulse_reset();
                end else begin
                    stream(len, 2);
                end
            end
            for (int j = 0; j < 4; j++) begin
                fetch_addr = 5'($urandom_range(0, 31));
                step();
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the processor's 32 x 13-bit instruction memory. Owns a writable instruction store and fills it from a valid/ready word stream, so programs are loaded at run time instead of being fixed at elaboration. The fetch stage reads the store through a combinational port. While a load is in progress the block holds the CPU and returns NOP (13'h0000) to fetch.

Parameters:
DATA_W, 13, instruction word width
ADDR_W, 5, fetch/write address width
DEPTH, 32, number of entries (2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle request to begin a load; sampled only in IDLE
load_len  in  ADDR_W+1  number of words to load (legal range 1..DEPTH); sampled with load_start
in_valid  in  1  stream word valid
in_data  in  DATA_W  stream instruction word
in_ready  out  1  block accepts in_data this cycle
fetch_addr  in  ADDR_W  fetch read address
fetch_instr  out  DATA_W  instruction at fetch_addr
cpu_hold  out  1  stall request to the processor
done  out  1  one-cycle pulse when a load completes
err  out  1  one-cycle pulse when load_len is illegal
loaded_len  out  ADDR_W+1  length of the last completed load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, cpu_hold=0, done=0, err=0, loaded_len=0; internal counters=0. The memory array is not reset.
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - load_start=1 with 1<=load_len<=DEPTH: latch len, wr_ptr=0, go to CLEAR next cycle.
  - load_start=1 with load_len==0 or load_len>DEPTH: err=1 for the next cycle only; stay in IDLE; memory and loaded_len unchanged.
- CLEAR:
  - Writes 0 to entry clr_ptr each cycle, clr_ptr running 0..DEPTH-1. This takes exactly DEPTH cycles.
  - After writing entry DEPTH-1, go to LOAD.
  - Every entry not loaded reads back as NOP.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: mem[wr_ptr]<=in_data, wr_ptr++.
  - in_valid=0 stalls with no time-out.
  - When the accepted word is number len, go to DONE; in_ready drops in that same next cycle.
- DONE (one cycle):
  - done=1 and loaded_len=len, both updated in this cycle.
  - Return to IDLE.
  - done is asserted the cycle after the last handshake.
- load_start outside IDLE is ignored (no restart, no err).
- in_valid outside LOAD is ignored; no write occurs.
- cpu_hold=1 in CLEAR, LOAD and DONE; 0 in IDLE.
- fetch_instr:
  - Combinational mem[fetch_addr] when cpu_hold=0.
  - Forced to 13'h0000 when cpu_hold=1.
  - No read latency.
- Pointer widths: wr_ptr and clr_ptr are ADDR_W+1 bits. The memory index uses the low ADDR_W bits. With len=DEPTH, the final write is entry DEPTH-1; there is no wrap to entry 0.
- Write-during-read: a write at edge N is visible on fetch_instr after edge N. This is only observable after the block leaves hold.
- Reset mid-operation:
  - Immediate return to IDLE; cpu_hold=0.
  - Entries already written keep their values; the remaining entries keep prior contents.
  - loaded_len=0; no done pulse.
- Total load latency from load_start to done: 1 + DEPTH + (handshake cycles) + 1.

Test Plan:
- Reset, then load_start with load_len=3, words 13'h1c00, 13'h1c11, 13'h0208 streamed back-to-back -> in_ready rises 33 cycles after load_start; done pulses once, the cycle after the 3rd handshake; loaded_len=3; fetch_addr 0/1/2 read 1c00/1c11/0208; fetch_addr 5 reads 0000.
- Full load, len=32, words = 13'h1000+i, with in_valid deasserted on every other cycle -> exactly 32 writes; fetch_addr 31 reads 101F; fetch_addr 0 reads 1000 (no wrap overwrite).
- load_len=0, and separately load_len=33 -> err single-cycle pulse each time; state stays IDLE; cpu_hold stays 0; prior contents and loaded_len intact.
- load 2 words, then a second load with len=1 word 13'h1e08 -> entry 0=1e08; entry 1=0000 (cleared); loaded_len=1.
- During CLEAR and LOAD, drive fetch_addr=0 -> fetch_instr=0000 and cpu_hold=1 throughout. A load_start pulse during LOAD has no effect.
- rst_n asserted after 2 of 4 words accepted -> next cycle cpu_hold=0, in_ready=0, loaded_len=0, no done pulse; entries 0 and 1 hold the streamed words; entries 2 and 3 read 0000.
